// File: rtl/multdiv_pkg.sv
// Shared constants and types for the multicycle multiply/divide sequencer.
package multdiv_pkg;

    localparam int unsigned MD_WIDTH = 32;
    localparam int unsigned MD_ITERS = 32;
    localparam int unsigned CNT_W    = 5;
    localparam int unsigned OP_W     = 5;

    localparam logic [OP_W-1:0] ALU_ADD = 5'b00000;
    localparam logic [OP_W-1:0] ALU_SUB = 5'b00001;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_NEGA = 3'd1,
        ST_NEGB = 3'd2,
        ST_ITER = 3'd3,
        ST_FIX  = 3'd4,
        ST_DONE = 3'd5
    } state_e;

endpackage

// File: rtl/multdiv_iter_step.sv
// One shift-add multiply or restoring divide step, using the shared ALU's result.
module multdiv_iter_step
    import multdiv_pkg::*;
#(
    parameter int unsigned WIDTH = MD_WIDTH
) (
    input  logic             is_div_i,
    input  logic [WIDTH-1:0] hi_i,
    input  logic [WIDTH-1:0] lo_i,
    input  logic             mcand_msb_i,
    input  logic [WIDTH-1:0] divisor_i,
    input  logic [WIDTH-1:0] alu_result_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    logic             carry;
    logic [WIDTH-1:0] rem_sh;
    logic             borrow;

    // Carry out of hi + |A|, recovered from the operand and sum MSBs.
    assign carry  = (hi_i[WIDTH-1] & mcand_msb_i)
                  | ((hi_i[WIDTH-1] | mcand_msb_i) & ~alu_result_i[WIDTH-1]);
    assign rem_sh = {hi_i[WIDTH-2:0], lo_i[WIDTH-1]};
    // The bit shifted out of R acts as the 33rd bit of the partial remainder.
    assign borrow = ~hi_i[WIDTH-1] & (rem_sh < divisor_i);

    always_comb begin
        hi_o = hi_i;
        lo_o = lo_i;
        if (is_div_i) begin
            if (!borrow) begin
                hi_o = alu_result_i;
                lo_o = {lo_i[WIDTH-2:0], 1'b1};
            end else begin
                hi_o = rem_sh;
                lo_o = {lo_i[WIDTH-2:0], 1'b0};
            end
        end else if (lo_i[0]) begin
            hi_o = {carry, alu_result_i[WIDTH-1:1]};
            lo_o = {alu_result_i[0], lo_i[WIDTH-1:1]};
        end else begin
            hi_o = {1'b0, hi_i[WIDTH-1:1]};
            lo_o = {hi_i[0], lo_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/multdiv_sequencer.sv
// Multicycle signed multiply/divide controller that borrows the execute-stage ALU
// while busy; fixed 36-cycle latency from start to the ready pulse.
module multdiv_sequencer
    import multdiv_pkg::*;
#(
    parameter int unsigned WIDTH = MD_WIDTH,
    parameter int unsigned ITERS = MD_ITERS
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] alu_operandA,
    output logic [WIDTH-1:0] alu_operandB,
    output logic [OP_W-1:0]  alu_opcode,
    output logic [4:0]       alu_shamt,
    input  logic [WIDTH-1:0] alu_result,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITERS - 1);
    localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             is_div_q, is_div_d;
    logic             sign_q, sign_d;
    logic             dbz_q, dbz_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             exc_q, exc_d;
    logic             rdy_q, rdy_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [OP_W-1:0]  alu_op_q, alu_op_d;
    logic [WIDTH-1:0] step_hi, step_lo;

    multdiv_iter_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .is_div_i    (is_div_q),
        .hi_i        (hi_q),
        .lo_i        (lo_q),
        .mcand_msb_i (a_q[WIDTH-1]),
        .divisor_i   (b_q),
        .alu_result_i(alu_result),
        .hi_o        (step_hi),
        .lo_o        (step_lo)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        is_div_d = is_div_q;
        sign_d   = sign_q;
        dbz_d    = dbz_q;
        result_d = result_q;
        exc_d    = exc_q;
        alu_a_d  = '0;
        alu_b_d  = '0;
        alu_op_d = ALU_ADD;

        case (state_q)
            ST_IDLE: begin
                if (ctrl_MULT || ctrl_DIV) begin
                    state_d  = ST_NEGA;
                    a_d      = data_operandA;
                    b_d      = data_operandB;
                    is_div_d = ~ctrl_MULT;
                    sign_d   = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                    dbz_d    = ~ctrl_MULT & (data_operandB == '0);
                end
            end
            ST_NEGA: begin
                a_d     = a_q[WIDTH-1] ? alu_result : a_q;
                state_d = ST_NEGB;
            end
            ST_NEGB: begin
                b_d     = b_q[WIDTH-1] ? alu_result : b_q;
                hi_d    = '0;
                lo_d    = is_div_q ? a_q : b_d;
                cnt_d   = '0;
                state_d = ST_ITER;
            end
            ST_ITER: begin
                hi_d = step_hi;
                lo_d = step_lo;
                if (cnt_q == LAST_CNT) begin
                    cnt_d   = '0;
                    state_d = ST_FIX;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_FIX: begin
                // alu_result holds 0 - magnitude in this cycle.
                if (is_div_q) begin
                    if (dbz_q) begin
                        result_d = '0;
                        exc_d    = 1'b1;
                    end else if (lo_q[WIDTH-1] && !sign_q) begin
                        result_d = MIN_NEG;
                        exc_d    = 1'b1;
                    end else begin
                        result_d = sign_q ? alu_result : lo_q;
                        exc_d    = 1'b0;
                    end
                end else begin
                    result_d = sign_q ? alu_result : lo_q;
                    exc_d    = (hi_q != '0)
                             | (lo_q[WIDTH-1] & ~(sign_q & (lo_q == MIN_NEG)));
                end
                state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // ALU drive is registered, so it is derived from the state being entered.
        case (state_d)
            ST_NEGA: begin
                alu_b_d  = a_d;
                alu_op_d = ALU_SUB;
            end
            ST_NEGB: begin
                alu_b_d  = b_d;
                alu_op_d = ALU_SUB;
            end
            ST_ITER: begin
                if (is_div_d) begin
                    alu_a_d  = {hi_d[WIDTH-2:0], lo_d[WIDTH-1]};
                    alu_b_d  = b_d;
                    alu_op_d = ALU_SUB;
                end else begin
                    alu_a_d  = hi_d;
                    alu_b_d  = a_d;
                    alu_op_d = ALU_ADD;
                end
            end
            ST_FIX: begin
                alu_b_d  = lo_d;
                alu_op_d = ALU_SUB;
            end
            default: ;
        endcase

        rdy_d  = (state_d == ST_DONE);
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            is_div_q <= 1'b0;
            sign_q   <= 1'b0;
            dbz_q    <= 1'b0;
            result_q <= '0;
            exc_q    <= 1'b0;
            rdy_q    <= 1'b0;
            busy_q   <= 1'b0;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            alu_op_q <= ALU_ADD;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            is_div_q <= is_div_d;
            sign_q   <= sign_d;
            dbz_q    <= dbz_d;
            result_q <= result_d;
            exc_q    <= exc_d;
            rdy_q    <= rdy_d;
            busy_q   <= busy_d;
            alu_a_q  <= alu_a_d;
            alu_b_q  <= alu_b_d;
            alu_op_q <= alu_op_d;
        end
    end

    assign alu_operandA   = alu_a_q;
    assign alu_operandB   = alu_b_q;
    assign alu_opcode     = alu_op_q;
    assign alu_shamt      = 5'd0;
    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign data_resultRDY = rdy_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Scoreboard bench for multdiv_sequencer with a behavioural shared ALU.
module tb_multdiv_sequencer;

    logic        clock;
    logic        reset;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] alu_operandA;
    logic [31:0] alu_operandB;
    logic [4:0]  alu_opcode;
    logic [4:0]  alu_shamt;
    logic [31:0] alu_result;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    typedef struct {
        logic [31:0] res;
        logic        exc;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;

    multdiv_sequencer dut (
        .clock         (clock),
        .reset         (reset),
        .ctrl_MULT     (ctrl_MULT),
        .ctrl_DIV      (ctrl_DIV),
        .data_operandA (data_operandA),
        .data_operandB (data_operandB),
        .alu_operandA  (alu_operandA),
        .alu_operandB  (alu_operandB),
        .alu_opcode    (alu_opcode),
        .alu_shamt     (alu_shamt),
        .alu_result    (alu_result),
        .data_result   (data_result),
        .data_exception(data_exception),
        .data_resultRDY(data_resultRDY),
        .busy          (busy)
    );

    // Shared ALU: only add and subtract are exercised.
    always_comb begin
        alu_result = alu_operandA + alu_operandB;
        if (alu_opcode == 5'b00001) alu_result = alu_operandA - alu_operandB;
    end

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle count %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every ready pulse must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (!reset && data_resultRDY) begin
            if (sb.size() == 0) begin
                check("unexpected_rdy", 32'(data_resultRDY), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result", data_result, e.res);
                check("exception", 32'(data_exception), 32'(e.exc));
                check("rdy_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    // Issue one operation; glitch_k > 0 pulses an extra MULT start in that busy cycle.
    task automatic run_op(input logic m, input logic d, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res,
                          input logic exp_exc, input int glitch_k);
        exp_t e;
        @(negedge clock);
        ctrl_MULT     = m;
        ctrl_DIV      = d;
        data_operandA = a;
        data_operandB = b;
        @(posedge clock);
        #1;
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
        e.res = exp_res;
        e.exc = exp_exc;
        e.cyc = cyc + 35;
        sb.push_back(e);
        for (int k = 1; k <= 36; k++) begin
            @(negedge clock);
            check("busy", 32'(busy), 32'd1);
            if (k == 1) begin
                check("nega_opcode", 32'(alu_opcode), 32'd1);
                check("nega_opB", alu_operandB, a);
            end
            if (k == 36) begin
                check("done_opcode", 32'(alu_opcode), 32'd0);
                check("done_opA", alu_operandA, 32'd0);
                check("done_opB", alu_operandB, 32'd0);
            end
            if (glitch_k > 0 && k == glitch_k) begin
                ctrl_MULT     = 1'b1;
                data_operandA = 32'd100;
                data_operandB = 32'd100;
            end
            if (glitch_k > 0 && k == glitch_k + 1) ctrl_MULT = 1'b0;
        end
        @(negedge clock);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_rdy", 32'(data_resultRDY), 32'd0);
        check("hold_result", data_result, exp_res);
        check("shamt", 32'(alu_shamt), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        reset         = 1'b1;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        repeat (3) @(negedge clock);
        check("rst_result", data_result, 32'd0);
        check("rst_exc", 32'(data_exception), 32'd0);
        check("rst_rdy", 32'(data_resultRDY), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_opA", alu_operandA, 32'd0);
        check("rst_opB", alu_operandB, 32'd0);
        check("rst_opcode", 32'(alu_opcode), 32'd0);
        reset = 1'b0;
        @(negedge clock);

        run_op(1'b1, 1'b0, 32'd7,          32'hFFFF_FFFA, 32'hFFFF_FFD6, 1'b0, 0);
        run_op(1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1, 0);
        run_op(1'b1, 1'b0, 32'h8000_0000, 32'd1,         32'h8000_0000, 1'b0, 0);
        run_op(1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 0);
        run_op(1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,         1'b0, 0);
        run_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b0, 0);
        run_op(1'b0, 1'b1, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, 0);
        run_op(1'b0, 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14,        1'b0, 0);
        run_op(1'b0, 1'b1, 32'd100,        32'd0,         32'd0,         1'b1, 0);
        run_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 0);
        run_op(1'b0, 1'b1, 32'h8000_0000, 32'd1,         32'h8000_0000, 1'b0, 0);
        run_op(1'b1, 1'b1, 32'd5,          32'd6,         32'd30,        1'b0, 10);

        // Abort a divide with reset in cycle 20; no result may follow.
        @(negedge clock);
        ctrl_DIV      = 1'b1;
        data_operandA = 32'd1000;
        data_operandB = 32'd7;
        @(posedge clock);
        #1;
        ctrl_DIV = 1'b0;
        repeat (20) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_rdy", 32'(data_resultRDY), 32'd0);
        check("abort_result", data_result, 32'd0);
        check("abort_exc", 32'(data_exception), 32'd0);
        check("abort_opcode", 32'(alu_opcode), 32'd0);
        repeat (40) @(negedge clock);

        run_op(1'b1, 1'b0, 32'd3, 32'd3, 32'd9, 1'b0, 0);

        repeat (3) @(negedge clock);
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
